// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer, instruction memory requests and instruction buffer feeding the decoder
module fetch_unit #(
  parameter type T = logic [31:0],
  parameter logic [8:0] RESET_PC = 9'h000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imem_en,
  output logic [8:0]  o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [8:0]  i_redirect_pc,
  output T            o_instruction,
  output logic [8:0]  o_pc,
  output logic        o_valid,
  input  logic        i_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [8:0] fetch_pc;
  logic [8:0] inflight_pc;
  logic inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  T mem_instr [DEPTH];
  logic [8:0] mem_pc [DEPTH];
  logic push;
  logic pop;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // Request only while a buffer slot is reserved for every outstanding read, so a stall never drops data
  always_comb begin
    o_imem_en = !reset && !i_redirect_valid && (({1'b0, count} + (CW + 1)'(inflight)) < (CW + 1)'(DEPTH));
    o_imem_addr = fetch_pc;
    push = inflight && !i_redirect_valid;
    o_valid = count != '0;
    pop = o_valid && i_ready;
    o_instruction = o_valid ? mem_instr[head] : '0;
    o_pc = o_valid ? mem_pc[head] : '0;
  end
  // PC sequencing, in-flight tracking and buffer occupancy; a redirect flushes everything
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (i_redirect_valid) begin
      fetch_pc <= i_redirect_pc & 9'h1FC;
      inflight <= 1'b0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      inflight <= o_imem_en;
      if (o_imem_en) begin
        fetch_pc <= fetch_pc + 9'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) tail <= wrap_inc(tail);
      if (pop) head <= wrap_inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  // Buffer storage: capture the memory word returned for last cycle's request
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i] <= '0;
      end
    end else if (push) begin
      mem_instr[tail] <= T'(i_imem_rdata);
      mem_pc[tail] <= inflight_pc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for the fetch unit against an in-order PC stream model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic o_imem_en;
  logic [8:0] o_imem_addr;
  logic [31:0] i_imem_rdata = '0;
  logic i_redirect_valid = 1'b0;
  logic [8:0] i_redirect_pc = '0;
  logic [31:0] o_instruction;
  logic [8:0] o_pc;
  logic o_valid;
  logic i_ready = 1'b1;
  int tests = 0;
  int fails = 0;
  int delivered = 0;
  logic [8:0] exp_q[$];
  logic [8:0] req_log[$];
  bit log_on = 0;

  fetch_unit #(.RESET_PC(9'h100)) dut (
    .clk(clk), .reset(reset), .o_imem_en(o_imem_en), .o_imem_addr(o_imem_addr),
    .i_imem_rdata(i_imem_rdata), .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] pc);
    return 32'h13 + {23'b0, pc};
  endfunction

  // instruction memory: one-cycle read latency, garbage when not read
  always @(posedge clk) i_imem_rdata <= o_imem_en ? word(o_imem_addr) : $urandom;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // expected delivery stream: consecutive word addresses from the start point, modulo 512
  task automatic restart(input logic [8:0] pc);
    exp_q.delete();
    for (int i = 0; i < 4096; i++) exp_q.push_back(9'((pc & 9'h1FC) + 4 * i));
  endtask

  task automatic do_redirect(input logic [8:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc = pc;
    @(negedge clk);
    @(posedge clk);
    restart(pc);
    #1 i_redirect_valid = 1'b0;
  endtask

  task automatic wait_deliv(input int n, input string name);
    int target;
    target = delivered + n;
    for (int i = 0; i < 300 && delivered < target; i++) @(negedge clk);
    check(name, 64'(delivered >= target), 1);
  endtask

  // monitor: every presented head must equal the model's next PC and its word; pop on handshake
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stream_overrun: got pc %0h expected none", o_pc);
      end else begin
        check("o_pc", o_pc, exp_q[0]);
        check("o_instruction", o_instruction, word(exp_q[0]));
        if (i_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end else check("idle_zero", {o_instruction, o_pc}, 0);
    if (o_imem_en) check("addr_align", o_imem_addr[1:0], 0);
    if (i_redirect_valid || reset) check("en_blocked", o_imem_en, 0);
    if (log_on && o_imem_en) req_log.push_back(o_imem_addr);
  end

  initial begin
    logic [8:0] stall_pc;
    int d0;
    restart(9'h100);
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_en", o_imem_en, 0);
    check("rst_pc", o_pc, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    log_on = 1;
    // reset release: first request and two-cycle latency
    @(negedge clk);
    check("t1_first_en", o_imem_en, 1);
    check("t1_first_addr", o_imem_addr, 9'h100);
    check("t1_valid_n0", o_valid, 0);
    @(negedge clk);
    check("t1_valid_n1", o_valid, 0);
    @(negedge clk);
    check("t1_valid_n2", o_valid, 1);
    check("t1_pc_n2", o_pc, 9'h100);
    wait_deliv(3, "t1_deliver");
    log_on = 0;
    if (req_log.size() < 3) begin
      tests++;
      fails++;
      $display("FAIL t1_req_count: got %0d expected >=3", req_log.size());
    end else begin
      check("t1_req0", req_log[0], 9'h100);
      check("t1_req1", req_log[1], 9'h104);
      check("t1_req2", req_log[2], 9'h108);
    end
    // stall: buffer fills, requests stop, head holds
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stall_pc = o_pc;
    check("t2_valid_mid", o_valid, 1);
    repeat (3) @(negedge clk);
    check("t2_en_full", o_imem_en, 0);
    check("t2_valid", o_valid, 1);
    check("t2_pc_hold", o_pc, stall_pc);
    // redirect while full
    @(posedge clk);
    #1 do_redirect(9'h0A6);
    @(negedge clk);
    check("t3_flushed", o_valid, 0);
    check("t3_en", o_imem_en, 1);
    check("t3_addr", o_imem_addr, 9'h0A4);
    @(negedge clk);
    check("t3_valid_n1", o_valid, 0);
    @(negedge clk);
    check("t3_valid_n2", o_valid, 1);
    check("t3_pc", o_pc, 9'h0A4);
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_deliv(3, "t2_resume");
    // redirect coincident with a handshake
    @(posedge clk);
    #1;
    for (int i = 0; i < 20 && !o_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("t4_valid", o_valid, 1);
    d0 = delivered;
    do_redirect(9'h040);
    check("t4_consumed", delivered, d0 + 1);
    wait_deliv(2, "t4_deliver");
    // wrap past the top of the address space
    @(posedge clk);
    #1 do_redirect(9'h1F8);
    wait_deliv(4, "t5_wrap");
    // asynchronous reset mid-stream
    @(posedge clk);
    #3 reset = 1'b1;
    restart(9'h100);
    #1;
    check("t6_valid", o_valid, 0);
    check("t6_en", o_imem_en, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_deliv(3, "t6_restart");
    // randomized back-pressure and redirects
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1 i_ready = ($urandom % 4) != 0;
      if ($urandom % 40 == 0) begin
        do_redirect(9'($urandom));
        if ($urandom % 3 == 0) do_redirect(9'($urandom));
      end
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_deliv(2, "final_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
